// File: rtl/cache_2way.sv
// ---------------------------------------------------------------------------
// cache_2way
//
// Two-way set-associative, write-through, no-write-allocate cache between a
// processor port (P_*) and a memory/bus port (S_*). One line holds one word;
// addresses are word addresses. Tag, data, valid and LRU storage are flop
// arrays. Replacement is per-set LRU. Flush invalidates every line in one
// cycle. Read hits and read misses are counted by saturating counters.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   P_strobe, P_rw      processor request valid, 1 = read / 0 = write
//   P_address           request word address
//   P_data_in           write data
//   P_data_out          read data, non-zero only while P_ready = 1
//   P_ready             one-cycle completion pulse
//   flush               invalidate all lines (honoured in IDLE only)
//   S_strobe, S_rw      memory request valid, 1 = read / 0 = write
//   S_address           memory word address
//   S_data_out          memory write data
//   S_data_in           memory read data, sampled with S_ready
//   S_ready             memory completion, one cycle per transfer
//   hit_count           saturating read-hit count
//   miss_count          saturating read-miss count
//   state_dbg           current FSM state (IDLE=0, CMP=1, MEM=2, RESP=3)
//
// Handshakes
//   Processor side: P_strobe is sampled only in IDLE; the requester holds
//   P_strobe/P_rw/P_address/P_data_in stable until the P_ready pulse, and
//   the request fields are latched at acceptance. Memory side: S_strobe and
//   all S_* outputs stay stable from the cycle S_strobe rises until the
//   cycle in which S_ready=1 is seen (that cycle included); S_ready while
//   S_strobe is low is ignored.
// ---------------------------------------------------------------------------
module cache_2way #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int INDEX_W = 6,
   parameter int TAG_W   = ADDR_W - INDEX_W,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              P_strobe,
   input  logic              P_rw,
   input  logic [ADDR_W-1:0] P_address,
   input  logic [DATA_W-1:0] P_data_in,
   output logic [DATA_W-1:0] P_data_out,
   output logic              P_ready,
   input  logic              flush,
   output logic              S_strobe,
   output logic              S_rw,
   output logic [ADDR_W-1:0] S_address,
   output logic [DATA_W-1:0] S_data_out,
   input  logic [DATA_W-1:0] S_data_in,
   input  logic              S_ready,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count,
   output logic [1:0]        state_dbg
);

   localparam int SETS = 1 << INDEX_W;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      MEM  = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t state;
   state_t state_nx;

   // Latched request
   logic              req_rw;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_data;

   // Line storage. lru[s] names the way to replace next in set s.
   logic [SETS-1:0]   valid0;
   logic [SETS-1:0]   valid1;
   logic [SETS-1:0]   lru;
   logic [TAG_W-1:0]  tag0  [SETS];
   logic [TAG_W-1:0]  tag1  [SETS];
   logic [DATA_W-1:0] data0 [SETS];
   logic [DATA_W-1:0] data1 [SETS];

   // Lookup of the latched request
   logic [INDEX_W-1:0] req_idx;
   logic [TAG_W-1:0]   req_tag;
   logic               hit0;
   logic               hit1;
   logic               hit;
   logic               hit_way;
   logic [DATA_W-1:0]  hit_data;
   logic               victim;
   logic               accept;
   logic               fill_en;
   logic               wr_hit_en;

   assign req_idx  = req_addr[INDEX_W-1:0];
   assign req_tag  = req_addr[ADDR_W-1:INDEX_W];
   assign hit0     = valid0[req_idx] && (tag0[req_idx] == req_tag);
   assign hit1     = valid1[req_idx] && (tag1[req_idx] == req_tag);
   assign hit      = hit0 || hit1;
   // A tag is never present in both ways of a set, so hit1 alone identifies the way.
   assign hit_way  = hit1;
   assign hit_data = hit1 ? data1[req_idx] : data0[req_idx];

   // Fill victim: an invalid way first (way0 preferred), otherwise the LRU way.
   assign victim = !valid0[req_idx] ? 1'b0 :
                   !valid1[req_idx] ? 1'b1 : lru[req_idx];

   // Flush wins over a pending strobe; the strobe is taken the next cycle.
   assign accept    = (state == IDLE) && !flush && P_strobe;
   assign fill_en   = (state == MEM) && S_ready && req_rw;
   assign wr_hit_en = (state == CMP) && !req_rw && hit;

   assign state_dbg = state;

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------------
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (accept) state_nx = CMP;
         end
         CMP: begin
            // Only a read hit completes locally; everything else goes to memory.
            if (req_rw && hit) state_nx = RESP;
            else               state_nx = MEM;
         end
         MEM: begin
            if (S_ready) state_nx = RESP;
         end
         RESP: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Request latch, valid/LRU bits, registered outputs and counters
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_rw     <= 1'b1;
         req_addr   <= '0;
         req_data   <= '0;
         valid0     <= '0;
         valid1     <= '0;
         lru        <= '0;
         P_ready    <= 1'b0;
         P_data_out <= '0;
         S_strobe   <= 1'b0;
         S_rw       <= 1'b1;
         S_address  <= '0;
         S_data_out <= '0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         // P_ready is a pulse: it is only ever set for the cycle spent in RESP.
         P_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (flush) begin
                  valid0 <= '0;
                  valid1 <= '0;
                  lru    <= '0;
               end else if (P_strobe) begin
                  req_rw   <= P_rw;
                  req_addr <= P_address;
                  req_data <= P_data_in;
               end
            end
            CMP: begin
               if (req_rw) begin
                  if (hit) begin
                     P_data_out   <= hit_data;
                     P_ready      <= 1'b1;
                     lru[req_idx] <= ~hit_way;
                     if (hit_count != CNT_MAX) hit_count <= hit_count + CNT_ONE;
                  end else begin
                     if (miss_count != CNT_MAX) miss_count <= miss_count + CNT_ONE;
                     S_strobe  <= 1'b1;
                     S_rw      <= 1'b1;
                     S_address <= req_addr;
                  end
               end else begin
                  // Write-through: a hit updates the line (see the array block)
                  // and the LRU bit; a miss allocates nothing.
                  if (hit) lru[req_idx] <= ~hit_way;
                  S_strobe   <= 1'b1;
                  S_rw       <= 1'b0;
                  S_address  <= req_addr;
                  S_data_out <= req_data;
               end
            end
            MEM: begin
               if (S_ready) begin
                  S_strobe <= 1'b0;
                  P_ready  <= 1'b1;
                  if (req_rw) begin
                     if (victim) valid1[req_idx] <= 1'b1;
                     else        valid0[req_idx] <= 1'b1;
                     lru[req_idx] <= ~victim;
                     P_data_out   <= S_data_in;
                  end
               end
            end
            RESP: begin
               P_data_out <= '0;
            end
            default: begin
               P_data_out <= '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Tag and data arrays. Their contents are meaningful only under a set
   // valid bit, so they carry no reset.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (wr_hit_en) begin
         if (hit_way) data1[req_idx] <= req_data;
         else         data0[req_idx] <= req_data;
      end else if (fill_en) begin
         if (victim) begin
            tag1[req_idx]  <= req_tag;
            data1[req_idx] <= S_data_in;
         end else begin
            tag0[req_idx]  <= req_tag;
            data0[req_idx] <= S_data_in;
         end
      end
   end

endmodule

// File: doc/cache_2way.md
Name: cache_2way

Overview:
- Parametrised 2-way set-associative, write-through, no-write-allocate cache between the processor port (P_*) and the memory/bus port (S_*).
- Replaces fixed wait-state slave timing with an explicit S_ready handshake.
- Adds per-set LRU replacement, a single-cycle flush, and saturating hit/miss counters.
- Tag/data/valid/LRU storage is flop arrays inside the block. There are no SRAM macros.

Parameters:
- ADDR_W, 32: word address width. There is no byte offset.
- DATA_W, 32: data word width. A line is one word.
- INDEX_W, 6: set index width, giving 2**INDEX_W sets. Index = P_address[INDEX_W-1:0].
- TAG_W, ADDR_W-INDEX_W: tag width. Tag = P_address[ADDR_W-1:INDEX_W].
- CNT_W, 16: width of the hit/miss counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- P_strobe  in  1  processor request valid.
- P_rw  in  1  1 = read, 0 = write.
- P_address  in  ADDR_W  request word address.
- P_data_in  in  DATA_W  write data.
- P_data_out  out  DATA_W  read data, valid while P_ready=1, else 0.
- P_ready  out  1  one-cycle completion pulse.
- flush  in  1  invalidate all lines.
- S_strobe  out  1  memory request valid.
- S_rw  out  1  1 = read, 0 = write.
- S_address  out  ADDR_W  memory word address.
- S_data_out  out  DATA_W  memory write data.
- S_data_in  in  DATA_W  memory read data, sampled when S_ready=1.
- S_ready  in  1  memory completion, one cycle per transfer.
- hit_count  out  CNT_W  saturating read-hit count.
- miss_count  out  CNT_W  saturating read-miss count.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state=IDLE; all valid bits and LRU bits =0; counters =0.
  - P_ready=0, P_data_out=0, S_strobe=0, S_rw=1, S_address=0, S_data_out=0.
  - Tag/data contents are not reset.
- All outputs are registered. Reset asserted mid-transaction aborts it: S_strobe drops immediately and no P_ready is issued.
- Request protocol:
  - P_strobe is sampled only in IDLE.
  - The requester holds P_strobe/P_rw/P_address/P_data_in stable until P_ready.
  - P_strobe high in the cycle after P_ready is a new request.
  - Inputs are latched on acceptance.
- States: IDLE, CMP, MEM, RESP.
- IDLE:
  - flush=1: clear all valid and LRU bits in that cycle. Flush has priority over P_strobe, and a pending strobe is accepted the next cycle. flush outside IDLE is ignored.
  - Else P_strobe=1: latch the request and go to CMP.
- CMP: compare the tag against both ways of the set. hit = valid & tag match.
  - Read hit: P_data_out <= hit way data; LRU[set] <= other way; hit_count++; go to RESP.
  - Read miss: miss_count++; S_strobe<=1, S_rw<=1, S_address<=latched address; go to MEM.
  - Write, hit or miss: if hit, write data into the hit way and set LRU[set] <= other way. Miss allocates nothing and leaves LRU unchanged. Then S_strobe<=1, S_rw<=0, S_address/S_data_out <= latched values; go to MEM.
- MEM:
  - Hold S_* stable until S_ready=1.
  - At the S_ready edge: S_strobe<=0 and go to RESP.
  - Read fill: choose victim = way0 if invalid, else way1 if invalid, else the LRU way. Write tag and data, set valid, set LRU[set] <= other way, P_data_out <= S_data_in.
- RESP: P_ready=1 for exactly one cycle, with P_data_out valid for reads (0 for writes). Then IDLE, and P_data_out returns to 0.
- Latency, with acceptance at cycle 0:
  - Read hit: P_ready in cycle 2.
  - Miss or write: S_strobe from cycle 2. If S_ready arrives in cycle n, P_ready is in cycle n+1.
  - S_ready in the same cycle S_strobe first rises is legal.
- S_ready outside MEM is ignored.
- Counters saturate at 2**CNT_W-1. Counters are not cleared by flush.
- Both ways valid in the same set with equal tags cannot occur: no allocation on hit.

Test Plan:
1. Reset then read 0x40 (set 0, tag 1), S_ready 3 cycles after S_strobe, S_data_in=0xDEADBEEF -> S_strobe/S_rw=1/S_address=0x40. P_ready one cycle after S_ready with 0xDEADBEEF; miss_count=1. Re-read 0x40 -> P_ready in cycle 2, no S_strobe, hit_count=1.
2. Fill 0x40 and 0x80 (both set 0), read 0x40, then read 0xC0 -> the 0x80 line is evicted (LRU). Read 0x40 hits; read 0x80 misses.
3. Write 0x40=0x12345678 on a hit -> S_rw=0 and S_data_out=0x12345678. A following read 0x40 hits and returns 0x12345678. Write to uncached 0x100 -> a later read 0x100 misses.
4. Read hits, then flush in IDLE with P_strobe held high -> strobe accepted one cycle later. Read 0x40 misses; hit_count is retained.
5. Assert rst during MEM with S_strobe=1 -> S_strobe=0 immediately, no P_ready, all valid bits 0. A following read 0x40 misses.
6. CNT_W=2: 4 read hits -> hit_count stays 3. S_ready asserted in IDLE has no effect.
